// File: rtl/bitrev_reorder_ctrl.sv
// bitrev_reorder_ctrl: buffers frames of N = 2**ADDR_W samples in natural order and
// replays each frame in bit-reversed address order.
// Optional build macro BITREV_PINGPONG_EN adds a second bank so that one frame can
// fill while the previous one drains; without it a single bank alternates FILL/DRAIN.
module bitrev_reorder_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);

  localparam int unsigned N = 2 ** ADDR_W;
`ifdef BITREV_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
  localparam int unsigned MemAw    = ADDR_W + 1;
`else
  localparam int unsigned NumBanks = 1;
  localparam int unsigned MemAw    = ADDR_W;
`endif
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic {StFill, StDrain} state_e;

  // Two state slots exist in both builds; the single-bank build pins both pointers
  // to slot 0, so slot 1 never leaves StFill.
  state_e st_q [2];
  state_e st_d [2];

  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              frame_err_q, frame_err_d;

  logic [DATA_W-1:0] mem_q [NumBanks*N];
  logic [MemAw-1:0]  wr_addr, rd_addr;

  logic in_fire, out_fire, fill_done, drain_done;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

`ifdef BITREV_PINGPONG_EN
  assign wr_addr = {wr_bank_q, wr_cnt_q};
  assign rd_addr = {rd_bank_q, bitrev(rd_cnt_q)};
`else
  assign wr_addr = wr_cnt_q;
  assign rd_addr = bitrev(rd_cnt_q);
`endif

  // Handshake outputs; both are held low while reset is asserted.
  always_comb begin
    in_ready  = rst_n & (st_q[wr_bank_q] == StFill);
    out_valid = rst_n & (st_q[rd_bank_q] == StDrain);
    out_last  = out_valid & (rd_cnt_q == LastAddr);
    out_data  = mem_q[rd_addr];
    frame_err = frame_err_q;
  end

  // Next-state: counters, per-bank FILL/DRAIN, bank pointers and the sticky error flag.
  always_comb begin
    in_fire    = in_valid & in_ready;
    out_fire   = out_valid & out_ready;
    fill_done  = in_fire & (wr_cnt_q == LastAddr);
    drain_done = out_fire & (rd_cnt_q == LastAddr);

    st_d        = st_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_err_d = frame_err_q;

    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      // in_last is only checked against the counter; it never ends a frame.
      if (in_last != (wr_cnt_q == LastAddr)) begin
        frame_err_d = 1'b1;
      end
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + ADDR_W'(1);
    end
    // Fill and drain always act on different banks, so both may land in one cycle.
    if (fill_done) begin
      st_d[wr_bank_q] = StDrain;
    end
    if (drain_done) begin
      st_d[rd_bank_q] = StFill;
    end

`ifdef BITREV_PINGPONG_EN
    wr_bank_d = wr_bank_q ^ fill_done;
    rd_bank_d = rd_bank_q ^ drain_done;
`else
    wr_bank_d = 1'b0;
    rd_bank_d = 1'b0;
`endif
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]     <= StFill;
      st_q[1]     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample storage; not reset, every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_addr] <= in_data;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Directed bench for bitrev_reorder_ctrl. Default build exercises the single-bank
// controller; building with BITREV_PINGPONG_EN exercises the two-bank variant.
module tb_bitrev_reorder_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last, frame_err;
  logic [DW-1:0] in_data, out_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned order [8];
  bit          err_exp;

  always #5 clk = ~clk;

  bitrev_reorder_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    next_cycle();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    next_cycle();
    rst_n   = 1'b1;
    err_exp = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_frame_err", frame_err, 0);
    next_cycle();
  endtask

`ifndef BITREV_PINGPONG_EN
  // Feeds samples base..base+7, collects max_out outputs. stall toggles out_ready 1,0;
  // junk keeps in_valid high with garbage once the frame is fed.
  task automatic run_frame(input int unsigned base, input int unsigned last_pos,
                           input bit stall, input bit junk, input int unsigned max_out);
    int unsigned k = 0, j = 0, cyc = 0;
    bit stalled = 0, expect_valid = 0;
    logic [DW-1:0] held_d = '0;
    logic held_l = 1'b0;
    while (j < max_out && cyc < 200) begin
      in_valid  = (k < 8) || junk;
      in_data   = (k < 8) ? DW'(base + k) : 8'hAA;
      in_last   = (k < 8) ? (k == last_pos) : 1'b1;
      out_ready = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      check("frame_err", frame_err, err_exp);
      if (expect_valid) begin
        check("latency", out_valid, 1);
        expect_valid = 0;
      end
      if (stalled) begin
        check("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      if (out_valid) check("in_ready_drain", in_ready, 0);
      else if (k < 8) check("in_ready_fill", in_ready, 1);
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      if (out_valid && out_ready) begin
        check("out_data", out_data, base + order[j]);
        check("out_last", out_last, (j == 7));
        j++;
      end
      if (in_valid && in_ready && k < 8) begin
        if (in_last != (k == 7)) err_exp = 1'b1;
        if (k == 7) expect_valid = 1;
        k++;
      end
      cyc++;
      next_cycle();
    end
    if (j < max_out) check("frame_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
`else
  // Three back-to-back frames with both sides always ready.
  task automatic run_pp_stream();
    int unsigned k = 0, j = 0, cyc = 0;
    out_ready = 1'b1;
    while (j < 24 && cyc < 200) begin
      in_valid = (k < 24);
      in_data  = DW'(k);
      in_last  = (k % 8 == 7);
      #1;
      if (k < 24) check("pp_in_ready", in_ready, 1);
      if (cyc >= 8) check("pp_out_valid_cont", out_valid, 1);
      if (out_valid && out_ready) begin
        check("pp_out_data", out_data, (j / 8) * 8 + order[j % 8]);
        check("pp_out_last", out_last, (j % 8 == 7));
        j++;
      end
      if (in_valid && in_ready) k++;
      cyc++;
      next_cycle();
    end
    if (j < 24) check("pp_timeout", 0, 1);
    in_valid = 1'b0;
    #1;
    check("pp_frame_err", frame_err, 0);
  endtask

  // Downstream blocked: both banks fill, then a single out_ready pulse.
  task automatic run_pp_backpressure();
    int unsigned k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(100 + k);
      in_last  = (k % 8 == 7);
      #1;
      if (in_valid && in_ready) k++;
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    check("pp_accepted", k, 16);
    check("pp_full_in_ready", in_ready, 0);
    check("pp_bp_first", out_data, 100);
    next_cycle();
    out_ready = 1'b1;
    #1;
    check("pp_pulse_valid", out_valid, 1);
    check("pp_pulse_data", out_data, 100);
    next_cycle();
    out_ready = 1'b0;
    #1;
    check("pp_after_pulse", out_data, 104);
    check("pp_after_last", out_last, 0);
  endtask
`endif

  initial begin
    order = '{0, 4, 2, 6, 1, 5, 3, 7};
    do_reset();
`ifndef BITREV_PINGPONG_EN
    run_frame(0, 7, 1'b0, 1'b1, 8);
    run_frame(0, 7, 1'b1, 1'b0, 8);
    run_frame(0, 4, 1'b0, 1'b0, 8);
    #1;
    check("err_sticky", frame_err, 1);
    next_cycle();
    run_frame(0, 7, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_last", out_last, 0);
    next_cycle();
    rst_n   = 1'b1;
    err_exp = 1'b0;
    #1;
    check("midrst_in_ready_after", in_ready, 1);
    check("midrst_out_valid_after", out_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    run_frame(8, 7, 1'b0, 1'b0, 8);
`else
    run_pp_stream();
    do_reset();
    run_pp_backpressure();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
